// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780-style LCD write path.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_IDLE,
    ST_READ,
    ST_LATCH,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_e;

  localparam logic [7:0] LCD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_HOME  = 8'h02;
  localparam logic [7:0] LCD_LINE2 = 8'hC0;

  localparam int unsigned DEF_T_PWRUP    = 750000;
  localparam int unsigned DEF_T_SETUP    = 4;
  localparam int unsigned DEF_T_PULSE    = 12;
  localparam int unsigned DEF_T_HOLD     = 4;
  localparam int unsigned DEF_T_CMD_WAIT = 2000;
  localparam int unsigned DEF_T_CLR_WAIT = 82000;
  localparam int unsigned DEF_N_CMD      = 4;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter; done is a registered pulse in the last cycle of a
// loaded interval, so a state loaded with N lasts exactly N cycles.
module lcd_delay_timer #(
  parameter int unsigned W         = 20,
  parameter int unsigned RST_VALUE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= W'(RST_VALUE);
      done <= (RST_VALUE <= 1);
    end else if (load) begin
      cnt  <= value;
      done <= (value <= W'(1));
    end else begin
      if (cnt != '0) cnt <= cnt - W'(1);
      done <= (cnt == W'(2));
    end
  end

endmodule

// File: rtl/lcd_write_sequencer.sv
// Drains the LCD init/character FIFO onto an 8-bit HD44780 bus with power-up,
// setup/enable/hold and execution timing; inserts a line-2 address after every 16th character.
module lcd_write_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned T_PWRUP    = DEF_T_PWRUP,
  parameter int unsigned T_SETUP    = DEF_T_SETUP,
  parameter int unsigned T_PULSE    = DEF_T_PULSE,
  parameter int unsigned T_HOLD     = DEF_T_HOLD,
  parameter int unsigned T_CMD_WAIT = DEF_T_CMD_WAIT,
  parameter int unsigned T_CLR_WAIT = DEF_T_CLR_WAIT,
  parameter int unsigned N_CMD      = DEF_N_CMD,
  parameter logic [7:0]  LINE2_ADDR = LCD_LINE2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_dout,
  output logic       fifo_rd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [7:0] lcd_data,
  output logic       busy
);

  localparam int unsigned CNT_W = $clog2(max_u(T_PWRUP, T_CLR_WAIT) + 1);

  lcd_state_e       state, state_d;
  logic             rd_en_d, e_d, rs_d, ins_pending, ins_pending_d;
  logic [7:0]       data_d, byte_idx, byte_idx_d;
  logic [3:0]       char_cnt, char_cnt_d;
  logic             tmr_load, tmr_done, is_char, long_wait;
  logic [CNT_W-1:0] tmr_value;

  lcd_delay_timer #(
    .W         (CNT_W),
    .RST_VALUE (T_PWRUP)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (tmr_value),
    .done  (tmr_done)
  );

  assign lcd_rw    = 1'b0;
  assign is_char   = (32'(byte_idx) >= N_CMD);
  assign long_wait = !lcd_rs && (lcd_data == LCD_CLEAR || lcd_data == LCD_HOME);

  // Next-state and next-output decode
  always_comb begin
    state_d       = state;
    rd_en_d       = 1'b0;
    e_d           = lcd_e;
    rs_d          = lcd_rs;
    data_d        = lcd_data;
    byte_idx_d    = byte_idx;
    char_cnt_d    = char_cnt;
    ins_pending_d = ins_pending;
    tmr_load      = 1'b0;
    tmr_value     = '0;
    unique case (state)
      ST_PWRUP: if (tmr_done) state_d = ST_IDLE;
      ST_IDLE: begin
        if (ins_pending) begin
          state_d       = ST_SETUP;
          data_d        = LINE2_ADDR;
          rs_d          = 1'b0;
          ins_pending_d = 1'b0;
          tmr_load      = 1'b1;
          tmr_value     = CNT_W'(T_SETUP);
        end else if (!fifo_empty) begin
          state_d = ST_READ;
          rd_en_d = 1'b1;
        end
      end
      ST_READ: state_d = ST_LATCH;
      ST_LATCH: begin
        data_d = fifo_dout;
        rs_d   = is_char;
        if (byte_idx != 8'hFF) byte_idx_d = byte_idx + 8'd1;
        if (is_char) begin
          char_cnt_d = char_cnt + 4'd1;
          if (char_cnt == 4'hF) ins_pending_d = 1'b1;
        end
        state_d   = ST_SETUP;
        tmr_load  = 1'b1;
        tmr_value = CNT_W'(T_SETUP);
      end
      ST_SETUP: if (tmr_done) begin
        state_d   = ST_PULSE;
        e_d       = 1'b1;
        tmr_load  = 1'b1;
        tmr_value = CNT_W'(T_PULSE);
      end
      ST_PULSE: if (tmr_done) begin
        state_d   = ST_HOLD;
        e_d       = 1'b0;
        tmr_load  = 1'b1;
        tmr_value = CNT_W'(T_HOLD);
      end
      ST_HOLD: if (tmr_done) begin
        state_d   = ST_WAIT;
        tmr_load  = 1'b1;
        tmr_value = long_wait ? CNT_W'(T_CLR_WAIT) : CNT_W'(T_CMD_WAIT);
      end
      ST_WAIT: if (tmr_done) state_d = ST_IDLE;
      default: state_d = ST_PWRUP;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_PWRUP;
      busy        <= 1'b1;
      fifo_rd_en  <= 1'b0;
      lcd_e       <= 1'b0;
      lcd_rs      <= 1'b0;
      lcd_data    <= 8'h00;
      byte_idx    <= 8'h00;
      char_cnt    <= 4'h0;
      ins_pending <= 1'b0;
    end else begin
      state       <= state_d;
      busy        <= (state_d != ST_IDLE);
      fifo_rd_en  <= rd_en_d;
      lcd_e       <= e_d;
      lcd_rs      <= rs_d;
      lcd_data    <= data_d;
      byte_idx    <= byte_idx_d;
      char_cnt    <= char_cnt_d;
      ins_pending <= ins_pending_d;
    end
  end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Randomized bench: predicts the LCD write sequence and its cycle timing from the byte stream.
module tb_lcd_write_sequencer;

  localparam int T_PWRUP    = 20;
  localparam int T_SETUP    = 2;
  localparam int T_PULSE    = 3;
  localparam int T_HOLD     = 2;
  localparam int T_CMD_WAIT = 10;
  localparam int T_CLR_WAIT = 40;
  localparam int N_CMD      = 4;

  typedef struct packed {
    logic       ins;
    logic       rs;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       fifo_empty;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_rd_en, lcd_rs, lcd_rw, lcd_e, busy;
  logic [7:0] lcd_data;

  int n_checks = 0;
  int n_fail   = 0;

  // FIFO model: stimulus owns the write pointer, the clocked block owns the read pointer
  logic [7:0] fifo_mem [0:255];
  int fifo_wp = 0;
  int fifo_rp = 0;

  // Expected LCD writes, in order
  wr_t exp_q [0:127];
  int  exp_wp = 0;
  int  exp_rp = 0;
  int  n_bytes = 0;
  int  n_chars = 0;
  logic streaming = 1'b0;

  always #5 clk = ~clk;

  assign fifo_empty = (fifo_wp == fifo_rp);

  lcd_write_sequencer #(
    .T_PWRUP    (T_PWRUP),
    .T_SETUP    (T_SETUP),
    .T_PULSE    (T_PULSE),
    .T_HOLD     (T_HOLD),
    .T_CMD_WAIT (T_CMD_WAIT),
    .T_CLR_WAIT (T_CLR_WAIT),
    .N_CMD      (N_CMD),
    .LINE2_ADDR (8'hC0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .lcd_rs     (lcd_rs),
    .lcd_rw     (lcd_rw),
    .lcd_e      (lcd_e),
    .lcd_data   (lcd_data),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Pushes a byte and appends the writes it must produce: leading N_CMD bytes are
  // instructions, later bytes characters, and every 16th character adds a 0xC0 write.
  task automatic push_byte(input logic [7:0] b);
    logic rs;
    rs = (n_bytes >= N_CMD);
    if (n_bytes < 255) n_bytes++;
    exp_q[exp_wp % 128] = '{ins: 1'b0, rs: rs, d: b};
    exp_wp++;
    if (rs) begin
      n_chars++;
      if (n_chars % 16 == 0) begin
        exp_q[exp_wp % 128] = '{ins: 1'b1, rs: 1'b0, d: 8'hC0};
        exp_wp++;
      end
    end
    fifo_mem[fifo_wp % 256] = b;
    fifo_wp++;
  endtask

  always @(posedge clk) begin
    if (!rst) fifo_rp <= fifo_wp;
    else if (fifo_rd_en && fifo_rp != fifo_wp) begin
      fifo_dout <= fifo_mem[fifo_rp % 256];
      fifo_rp   <= fifo_rp + 1;
    end
  end

  // Bus monitor: content, setup/hold stability, E width, pop count and inter-write gap
  int   cyc = 0, rise_cyc = 0, fall_cyc = 0, rd_cyc = 0;
  int   stable_cnt = 0, hold_left = 0, rd_since_rise = 0, prev_wait = 0;
  logic e_prev = 1'b0, rd_prev = 1'b0, prev_valid = 1'b0;
  logic [8:0] last_bus = 9'h0, rise_bus = 9'h0, hold_bus = 9'h0;
  wr_t  cur;

  always @(negedge clk) begin
    if (!rst) begin
      e_prev = 1'b0; rd_prev = 1'b0; prev_valid = 1'b0;
      rd_since_rise = 0; stable_cnt = 0; hold_left = 0;
      exp_rp = exp_wp;
    end else begin
      cyc++;
      if (fifo_rd_en) begin
        check("rd_single", 32'(rd_prev), 32'd0);
        rd_since_rise++;
        rd_cyc = cyc;
      end
      rd_prev = fifo_rd_en;
      if ({lcd_rs, lcd_data} == last_bus) stable_cnt++;
      else stable_cnt = 0;
      last_bus = {lcd_rs, lcd_data};
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) check("hold_bus", 32'({lcd_rs, lcd_data}), 32'(hold_bus));
      end
      if (lcd_e && !e_prev) begin
        rise_cyc = cyc;
        rise_bus = {lcd_rs, lcd_data};
        if (exp_rp == exp_wp) check("extra_write", 32'(exp_rp), 32'(exp_wp + 1));
        else begin
          cur = exp_q[exp_rp % 128];
          exp_rp++;
          check("wr_data", 32'(lcd_data), 32'(cur.d));
          check("wr_rs", 32'(lcd_rs), 32'(cur.rs));
          check("setup_stable", 32'(stable_cnt >= T_SETUP), 32'd1);
          check("pops_per_write", 32'(rd_since_rise), cur.ins ? 32'd0 : 32'd1);
          if (!cur.ins) check("rd_to_e", 32'(cyc - rd_cyc), 32'(2 + T_SETUP));
          if (streaming && prev_valid)
            check("write_gap", 32'(cyc - fall_cyc),
                  32'(T_HOLD + prev_wait + 1 + (cur.ins ? 0 : 2) + T_SETUP));
        end
        rd_since_rise = 0;
      end
      if (!lcd_e && e_prev) begin
        check("e_width", 32'(cyc - rise_cyc), 32'(T_PULSE));
        check("e_bus", 32'({lcd_rs, lcd_data}), 32'(rise_bus));
        fall_cyc   = cyc;
        prev_wait  = (!lcd_rs && (lcd_data == 8'h01 || lcd_data == 8'h02)) ? T_CLR_WAIT : T_CMD_WAIT;
        prev_valid = 1'b1;
        hold_left  = T_HOLD;
        hold_bus   = {lcd_rs, lcd_data};
      end
      e_prev = lcd_e;
    end
  end

  // Counts cycles from reset release to the first pop
  task automatic measure_pwrup();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!fifo_rd_en && n < 200);
    check("pwrup_latency", 32'(n), 32'(T_PWRUP + 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_rp != exp_wp || busy) && n < 5000);
    check("drain_pending", 32'(exp_wp - exp_rp), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int bad, n;
    rst = 1'b1;
    #3 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_e", 32'(lcd_e), 32'd0);
    check("rst_rs", 32'(lcd_rs), 32'd0);
    check("rst_rw", 32'(lcd_rw), 32'd0);
    check("rst_data", 32'(lcd_data), 32'd0);

    // 4 commands, 'K', then 16 random characters (one is 0x02, which must use the short wait)
    @(negedge clk);
    rst = 1'b1;
    push_byte(8'h38); push_byte(8'h0C); push_byte(8'h01); push_byte(8'h06); push_byte(8'h4B);
    for (int i = 0; i < 16; i++)
      push_byte((i == 5) ? 8'h02 : 8'($urandom_range(32, 126)));
    streaming = 1'b1;
    measure_pwrup();
    drain();
    check("rw_low", 32'(lcd_rw), 32'd0);

    // Idle with an empty FIFO, then a late byte
    streaming = 1'b0;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy || fifo_rd_en || lcd_e) bad++;
    end
    check("idle_quiet", 32'(bad), 32'd0);
    repeat ($urandom_range(1, 8)) @(negedge clk);
    push_byte(8'($urandom_range(32, 126)));
    @(negedge clk);
    check("idle_latency", 32'(fifo_rd_en), 32'd1);
    drain();

    // Reset while E is high
    push_byte(8'h55);
    n = 0;
    while (!lcd_e && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("e_seen", 32'(lcd_e), 32'd1);
    #2 rst = 1'b0;
    n_bytes = 0;
    n_chars = 0;
    #1;
    check("midrst_e", 32'(lcd_e), 32'd0);
    check("midrst_data", 32'(lcd_data), 32'd0);
    check("midrst_rs", 32'(lcd_rs), 32'd0);
    check("midrst_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    streaming = 1'b1;
    push_byte(8'h41);
    push_byte(8'h01);
    push_byte(8'h0C);
    measure_pwrup();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
